// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slews the pwm duty toward a requested target at a fixed
// step rate, reverses direction through zero duty plus a dead time, and
// latches an emergency-stop fault until enable is dropped to re-arm.
module motor_ramp_ctrl #(
    parameter int unsigned STEP_DIV    = 50000,
    parameter int unsigned STEP_SIZE   = 1,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       estop,
    input  logic [7:0] target_duty,
    input  logic       target_dir,
    output logic [7:0] duty_cycle,
    output logic       dir,
    output logic       busy,
    output logic       at_target,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        HOLD    = 3'd2,
        REVERSE = 3'd3,
        DEAD    = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [19:0] PRESC_MAX = 20'(STEP_DIV - 1);
    localparam logic [19:0] DEAD_MAX  = 20'(DEAD_CYCLES - 1);
    localparam logic [8:0]  STEP      = 9'(STEP_SIZE);

    state_t      state;
    state_t      next_state;
    logic [19:0] prescaler;
    logic [19:0] prescaler_next;
    logic [19:0] dead_cnt;
    logic [19:0] dead_next;
    logic [7:0]  duty_next;
    logic        dir_next;

    logic        tick;
    logic        dir_mismatch;
    logic [7:0]  eff_target;

    logic        up_eff;
    logic [8:0]  dist_eff;
    logic [8:0]  amt_eff;
    logic [8:0]  sum_eff;
    logic [8:0]  amt_zero;
    logic [8:0]  sum_zero;
    logic        unused_msb;

    assign tick         = (prescaler == PRESC_MAX);
    assign dir_mismatch = (target_dir != dir);
    assign eff_target   = (!enable || dir_mismatch) ? 8'd0 : target_duty;
    assign unused_msb   = sum_eff[8] ^ sum_zero[8];

    // One clamped ramp step toward the effective target and toward zero, in 9 bits so nothing wraps
    always_comb begin
        up_eff   = (eff_target >= duty_cycle);
        dist_eff = up_eff ? ({1'b0, eff_target} - {1'b0, duty_cycle})
                          : ({1'b0, duty_cycle} - {1'b0, eff_target});
        amt_eff  = (dist_eff < STEP) ? dist_eff : STEP;
        sum_eff  = up_eff ? ({1'b0, duty_cycle} + amt_eff)
                          : ({1'b0, duty_cycle} - amt_eff);
        amt_zero = ({1'b0, duty_cycle} < STEP) ? {1'b0, duty_cycle} : STEP;
        sum_zero = {1'b0, duty_cycle} - amt_zero;
    end

    // Next state, next duty/dir and dead counter; estop overrides everything
    always_comb begin
        next_state = state;
        duty_next  = duty_cycle;
        dir_next   = dir;
        dead_next  = dead_cnt;
        if (estop) begin
            next_state = FAULT;
            duty_next  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    duty_next = 8'd0;
                    if (enable && dir_mismatch) begin
                        next_state = DEAD;
                        dead_next  = 20'd0;
                    end else if (enable && (target_duty != 8'd0)) begin
                        next_state = RAMP;
                    end
                end
                RAMP: begin
                    if (enable && dir_mismatch) begin
                        next_state = REVERSE;
                    end else if (duty_cycle == eff_target) begin
                        next_state = (eff_target != 8'd0) ? HOLD : IDLE;
                    end else if (tick) begin
                        duty_next = sum_eff[7:0];
                    end
                end
                HOLD: begin
                    if (enable && dir_mismatch) begin
                        next_state = REVERSE;
                    end else if (tick && (eff_target != duty_cycle)) begin
                        next_state = RAMP;
                    end
                end
                REVERSE: begin
                    if (duty_cycle == 8'd0) begin
                        if (!enable) begin
                            next_state = IDLE;
                        end else begin
                            next_state = DEAD;
                            dead_next  = 20'd0;
                        end
                    end else if (tick) begin
                        duty_next = sum_zero[7:0];
                    end
                end
                DEAD: begin
                    duty_next = 8'd0;
                    if (dead_cnt == DEAD_MAX) begin
                        dir_next   = target_dir;
                        dead_next  = 20'd0;
                        next_state = (enable && (target_duty != 8'd0)) ? RAMP : IDLE;
                    end else begin
                        dead_next = dead_cnt + 20'd1;
                    end
                end
                FAULT: begin
                    duty_next = 8'd0;
                    if (!enable) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    duty_next  = 8'd0;
                end
            endcase
        end
    end

    // Step prescaler: restarts on entry to RAMP/REVERSE, free-runs while ramping or holding
    always_comb begin
        prescaler_next = 20'd0;
        if (((next_state == RAMP) || (next_state == REVERSE)) && (next_state != state)) begin
            prescaler_next = 20'd0;
        end else if ((state == RAMP) || (state == REVERSE) || (state == HOLD)) begin
            prescaler_next = tick ? 20'd0 : (prescaler + 20'd1);
        end
    end

    // State, datapath and registered flag decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            duty_cycle <= 8'd0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            at_target  <= 1'b0;
            fault      <= 1'b0;
            prescaler  <= 20'd0;
            dead_cnt   <= 20'd0;
        end else begin
            state      <= next_state;
            duty_cycle <= duty_next;
            dir        <= dir_next;
            busy       <= (next_state == RAMP) || (next_state == REVERSE) || (next_state == DEAD);
            at_target  <= (next_state == HOLD);
            fault      <= (next_state == FAULT);
            prescaler  <= prescaler_next;
            dead_cnt   <= dead_next;
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed, table-driven checks of the ramp controller
// with STEP_DIV=4, STEP_SIZE=8, DEAD_CYCLES=16, plus a second instance with
// STEP_SIZE=200 for the clamp/no-wrap corners.
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;

    logic       rst_n;
    logic       enable;
    logic       estop;
    logic [7:0] target_duty;
    logic       target_dir;
    logic [7:0] duty_cycle;
    logic       dir;
    logic       busy;
    logic       at_target;
    logic       fault;

    logic       rst2_n;
    logic       enable2;
    logic       estop2;
    logic [7:0] target_duty2;
    logic       target_dir2;
    logic [7:0] duty2;
    logic       dir2;
    logic       busy2;
    logic       at2;
    logic       fault2;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       enable;
        logic       estop;
        logic [7:0] tduty;
        logic       tdir;
        int         cycles;
        logic [7:0] exp_duty;
        logic       exp_dir;
        logic       exp_busy;
        logic       exp_at;
        logic       exp_fault;
    } vec_t;

    vec_t vecs[$];

    motor_ramp_ctrl #(.STEP_DIV(4), .STEP_SIZE(8), .DEAD_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .estop(estop),
        .target_duty(target_duty), .target_dir(target_dir),
        .duty_cycle(duty_cycle), .dir(dir), .busy(busy),
        .at_target(at_target), .fault(fault)
    );

    motor_ramp_ctrl #(.STEP_DIV(4), .STEP_SIZE(200), .DEAD_CYCLES(16)) dut2 (
        .clk(clk), .rst_n(rst2_n), .enable(enable2), .estop(estop2),
        .target_duty(target_duty2), .target_dir(target_dir2),
        .duty_cycle(duty2), .dir(dir2), .busy(busy2),
        .at_target(at2), .fault(fault2)
    );

    always #5 clk = ~clk;

    function automatic void addVec(input string name, input logic r, input logic e,
                                   input logic s, input logic [7:0] t, input logic d,
                                   input int n, input logic [7:0] ed, input logic edir,
                                   input logic eb, input logic ea, input logic ef);
        vec_t v;
        v.name = name; v.rst_n = r; v.enable = e; v.estop = s; v.tduty = t; v.tdir = d;
        v.cycles = n; v.exp_duty = ed; v.exp_dir = edir; v.exp_busy = eb;
        v.exp_at = ea; v.exp_fault = ef;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] dut1Out();
        return {duty_cycle, dir, busy, at_target, fault};
    endfunction

    function automatic logic [11:0] dut2Out();
        return {duty2, dir2, busy2, at2, fault2};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got duty=%0d dir=%b busy=%b at_target=%b fault=%b, expected duty=%0d dir=%b busy=%b at_target=%b fault=%b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n       = v.rst_n;
        enable      = v.enable;
        estop       = v.estop;
        target_duty = v.tduty;
        target_dir  = v.tdir;
        waitCycles(v.cycles);
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, dut1Out(),
                        {vecs[i].exp_duty, vecs[i].exp_dir, vecs[i].exp_busy,
                         vecs[i].exp_at, vecs[i].exp_fault});
        end
    endtask

    initial begin
        logic [7:0] prev_duty;
        logic       prev_dir;
        int         zero_run;
        int         zero_at_flip;
        int         flip_k;
        int         flips;
        logic [7:0] changes[$];
        logic [7:0] exp_chg[10];

        rst_n = 1'b0; enable = 1'b0; estop = 1'b0; target_duty = 8'd0; target_dir = 1'b0;
        rst2_n = 1'b0; enable2 = 1'b0; estop2 = 1'b0; target_duty2 = 8'd0; target_dir2 = 1'b0;

        //     name            rst en es tduty dir  n    duty dir bsy at flt
        addVec("reset",         0, 1, 0,  40,  0,   2,    0,  0,  0, 0, 0);
        addVec("t1_start",      1, 1, 0,  40,  0,   1,    0,  0,  1, 0, 0);
        addVec("t1_step8",      1, 1, 0,  40,  0,   4,    8,  0,  1, 0, 0);
        addVec("t1_step16",     1, 1, 0,  40,  0,   4,   16,  0,  1, 0, 0);
        addVec("t1_step24",     1, 1, 0,  40,  0,   4,   24,  0,  1, 0, 0);
        addVec("t1_step32",     1, 1, 0,  40,  0,   4,   32,  0,  1, 0, 0);
        addVec("t1_step40",     1, 1, 0,  40,  0,   4,   40,  0,  1, 0, 0);
        addVec("t1_hold",       1, 1, 0,  40,  0,   1,   40,  0,  0, 1, 0);
        addVec("t2_to_ramp",    1, 1, 0,  37,  0,   3,   40,  0,  1, 0, 0);
        addVec("t2_step37",     1, 1, 0,  37,  0,   4,   37,  0,  1, 0, 0);
        addVec("t2_hold",       1, 1, 0,  37,  0,   1,   37,  0,  0, 1, 0);
        addVec("t2_back_hold",  1, 1, 0,  40,  0,   8,   40,  0,  0, 1, 0);
        addVec("t4_reset",      0, 1, 0,  40,  0,   1,    0,  0,  0, 0, 0);
        addVec("t4_ramp24",     1, 1, 0,  40,  0,  13,   24,  0,  1, 0, 0);
        addVec("t4_down16",     1, 0, 0,  40,  0,   4,   16,  0,  1, 0, 0);
        addVec("t4_down8",      1, 0, 0,  40,  0,   4,    8,  0,  1, 0, 0);
        addVec("t4_down0",      1, 0, 0,  40,  0,   4,    0,  0,  1, 0, 0);
        addVec("t4_idle",       1, 0, 0,  40,  0,   1,    0,  0,  0, 0, 0);
        addVec("t5_reset",      0, 0, 0, 200,  0,   1,    0,  0,  0, 0, 0);
        addVec("t5_hold200",    1, 1, 0, 200,  0, 102,  200,  0,  0, 1, 0);
        addVec("t5_estop",      1, 1, 1, 200,  0,   1,    0,  0,  0, 0, 1);
        addVec("t5_latched",    1, 1, 0, 200,  0,   3,    0,  0,  0, 0, 1);
        addVec("t5_rearm",      1, 0, 0, 200,  0,   1,    0,  0,  0, 0, 0);
        addVec("t5_restart",    1, 1, 0, 200,  0,   1,    0,  0,  1, 0, 0);
        addVec("t5_first8",     1, 1, 0, 200,  0,   4,    8,  0,  1, 0, 0);
        addVec("t6_reset",      0, 1, 0, 100,  0,   1,    0,  0,  0, 0, 0);
        addVec("t6_mid100",     1, 1, 0, 100,  0,  53,  100,  0,  1, 0, 0);

        exp_chg = '{8'd32, 8'd24, 8'd16, 8'd8, 8'd0, 8'd8, 8'd16, 8'd24, 8'd32, 8'd40};

        @(posedge clk);
        #1;

        runVectors(0, 11);

        // Reversal from HOLD at 40: down to 0, dead time, dir flip, back up to 40
        target_dir   = 1'b1;
        prev_duty    = duty_cycle;
        prev_dir     = dir;
        zero_run     = 0;
        zero_at_flip = -1;
        flip_k       = -1;
        flips        = 0;
        for (int k = 1; k <= 59; k++) begin
            waitCycles(1);
            if (dir != prev_dir) begin
                flips++;
                flip_k       = k;
                zero_at_flip = zero_run;
                checkValue("t3_duty_zero_at_flip", int'(prev_duty) + int'(duty_cycle), 0);
            end
            if (duty_cycle != prev_duty) changes.push_back(duty_cycle);
            zero_run  = (duty_cycle == 8'd0) ? zero_run + 1 : 0;
            prev_duty = duty_cycle;
            prev_dir  = dir;
        end
        checkValue("t3_flip_count", flips, 1);
        checkValue("t3_flip_cycle", flip_k, 38);
        checkValue("t3_dead_at_least_16", int'(zero_at_flip >= 16), 1);
        checkValue("t3_change_count", changes.size(), 10);
        for (int i = 0; i < 10; i++) begin
            checkValue($sformatf("t3_duty_seq_%0d", i),
                       (i < changes.size()) ? int'(changes[i]) : -1, int'(exp_chg[i]));
        end
        checkOutput("t3_hold_reverse", dut1Out(), {8'd40, 1'b1, 1'b0, 1'b1, 1'b0});

        runVectors(12, 26);

        // Asynchronous reset mid-ramp takes effect before the next edge
        rst_n = 1'b0;
        #2;
        checkOutput("t6_async_reset", dut1Out(), 12'd0);
        waitCycles(1);
        enable = 1'b0;
        rst_n  = 1'b1;
        waitCycles(1);
        checkOutput("t6_idle_after", dut1Out(), 12'd0);
        enable = 1'b1;
        waitCycles(1);
        checkOutput("t6_restart", dut1Out(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b0});

        // Large step size: clamps at 255 going up and at 0 going down
        enable2      = 1'b1;
        target_duty2 = 8'd255;
        rst2_n       = 1'b1;
        waitCycles(1);
        checkOutput("t6b_start", dut2Out(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        waitCycles(4);
        checkOutput("t6b_step200", dut2Out(), {8'd200, 1'b0, 1'b1, 1'b0, 1'b0});
        waitCycles(4);
        checkOutput("t6b_step255", dut2Out(), {8'd255, 1'b0, 1'b1, 1'b0, 1'b0});
        waitCycles(1);
        checkOutput("t6b_hold255", dut2Out(), {8'd255, 1'b0, 1'b0, 1'b1, 1'b0});
        target_duty2 = 8'd0;
        waitCycles(7);
        checkOutput("t6b_down55", dut2Out(), {8'd55, 1'b0, 1'b1, 1'b0, 1'b0});
        waitCycles(4);
        checkOutput("t6b_down0", dut2Out(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        waitCycles(1);
        checkOutput("t6b_idle", dut2Out(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
